// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Drives two LEDs from a small hard-coded table of blink patterns. A single
// shared prescaler divides the system clock into ticks; a step sequencer walks
// the selected pattern, holding each step for (dur+1) ticks.
//
// Ports:
//   clk        in   1  system clock (only clock of this block)
//   rst        in   1  asynchronous, active-low reset
//   start      in   1  one-cycle request to begin a pattern (accepted in IDLE)
//   stop       in   1  one-cycle abort request
//   mode       in   2  pattern select, captured on an accepted start
//   repeat_en  in   1  loop enable, captured on an accepted start
//   led        out  2  registered LED drive
//   busy       out  1  high while a pattern is running
//   done       out  1  one-cycle pulse at the natural end of a one-shot pattern
//   step_idx   out  3  registered index of the current step
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int unsigned TICK_DIV   = 600000,
    parameter int unsigned TICK_WIDTH = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] mode,
    input  logic       repeat_en,
    output logic [1:0] led,
    output logic       busy,
    output logic       done,
    output logic [2:0] step_idx
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [TICK_WIDTH-1:0] PRESC_LAST = TICK_WIDTH'(TICK_DIV - 1);

    // Table entry layout: {last, led[1:0], dur[4:0]}, indexed by {mode, step}.
    // Steps past the last one of a pattern are never reached; they are filled
    // with a dark, terminating entry so the table is fully defined.
    localparam logic [7:0] PAD_STEP = {1'b1, 2'b00, 5'd0};

    localparam logic [7:0] PATTERN_ROM [0:31] = '{
        // mode 0: alternate
        {1'b0, 2'b01, 5'd9},  {1'b1, 2'b10, 5'd9},
        PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP,
        // mode 1: blink both
        {1'b0, 2'b11, 5'd3},  {1'b1, 2'b00, 5'd3},
        PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP,
        // mode 2: chase
        {1'b0, 2'b01, 5'd1},  {1'b0, 2'b10, 5'd1},
        {1'b0, 2'b11, 5'd1},  {1'b1, 2'b00, 5'd5},
        PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP,
        // mode 3: heartbeat
        {1'b0, 2'b11, 5'd1},  {1'b0, 2'b00, 5'd1},
        {1'b0, 2'b11, 5'd1},  {1'b1, 2'b00, 5'd13},
        PAD_STEP, PAD_STEP, PAD_STEP, PAD_STEP
    };

    // State and datapath registers
    logic [0:0]            state_q,    state_d;
    logic [1:0]            mode_q,     mode_d;
    logic                  repeat_q,   repeat_d;
    logic [TICK_WIDTH-1:0] presc_q,    presc_d;
    logic [4:0]            tick_cnt_q, tick_cnt_d;
    logic [2:0]            step_q,     step_d;
    logic [1:0]            led_q,      led_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic [2:0] next_step;
    logic [4:0] cur_idx;
    logic [4:0] next_idx;
    logic [4:0] start_idx;
    logic       tick;
    logic       cur_last;
    logic [4:0] cur_dur;

    assign next_step = step_q + 3'd1;
    assign cur_idx   = {mode_q, step_q};
    assign next_idx  = {mode_q, next_step};
    // The first LED value comes from the live mode input so that it appears on
    // the same edge that accepts start.
    assign start_idx = {mode, 3'd0};

    assign tick     = (presc_q == PRESC_LAST);
    assign cur_last = PATTERN_ROM[cur_idx][7];
    assign cur_dur  = PATTERN_ROM[cur_idx][4:0];

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        repeat_d   = repeat_q;
        presc_d    = presc_q;
        tick_cnt_d = tick_cnt_q;
        step_d     = step_q;
        led_d      = led_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Counters stay parked while idle.
                presc_d    = '0;
                tick_cnt_d = '0;
                step_d     = 3'd0;
                led_d      = 2'b00;
                busy_d     = 1'b0;
                // A coincident stop cancels the start.
                if (start && !stop) begin
                    state_d  = ST_RUN;
                    mode_d   = mode;
                    repeat_d = repeat_en;
                    led_d    = PATTERN_ROM[start_idx][6:5];
                    busy_d   = 1'b1;
                end
            end

            default: begin // ST_RUN
                if (stop) begin
                    state_d    = ST_IDLE;
                    presc_d    = '0;
                    tick_cnt_d = '0;
                    step_d     = 3'd0;
                    led_d      = 2'b00;
                    busy_d     = 1'b0;
                end else if (tick) begin
                    presc_d = '0;
                    if (tick_cnt_q == cur_dur) begin
                        tick_cnt_d = '0;
                        if (!cur_last) begin
                            step_d = next_step;
                            led_d  = PATTERN_ROM[next_idx][6:5];
                        end else if (repeat_q) begin
                            // Loop straight back to step 0, no idle cycle.
                            step_d = 3'd0;
                            led_d  = PATTERN_ROM[{mode_q, 3'd0}][6:5];
                        end else begin
                            state_d = ST_IDLE;
                            step_d  = 3'd0;
                            led_d   = 2'b00;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 5'd1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= 2'b00;
            repeat_q   <= 1'b0;
            presc_q    <= '0;
            tick_cnt_q <= '0;
            step_q     <= 3'd0;
            led_q      <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            repeat_q   <= repeat_d;
            presc_q    <= presc_d;
            tick_cnt_q <= tick_cnt_d;
            step_q     <= step_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_sequencer
//
// Scoreboard bench for led_pattern_sequencer with TICK_DIV=4. The stimulus
// process pushes every expected output change {cycle, led, busy, done, step}
// into a queue; the monitor watches the output tuple and, whenever it changes,
// pops the next expectation and compares both the value and the cycle of the
// change. Any change with nothing expected is an error.
// -----------------------------------------------------------------------------
module tb_led_pattern_sequencer;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic       repeat_en;
    logic [1:0] led;
    logic       busy;
    logic       done;
    logic [2:0] step_idx;

    led_pattern_sequencer #(
        .TICK_DIV   (TD),
        .TICK_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .repeat_en (repeat_en),
        .led       (led),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    always #5 if (clk_en) clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [6:0] out;   // {led, busy, done, step_idx}
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    string test_name = "reset";

    // ---------------------------------------------------------------- monitor
    logic [6:0] prev_out;
    bit         have_prev = 1'b0;

    initial begin : monitor
        logic [6:0] cur;
        exp_t       e;
        forever begin
            @(negedge clk or negedge rst);
            #1;
            if (mon_en) begin
                cur = {led, busy, done, step_idx};
                if (!have_prev || cur != prev_out) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s unexpected change: cyc=%0d led=%b busy=%b done=%b step=%0d, required no change",
                                 test_name, cyc, cur[6:5], cur[4], cur[3], cur[2:0]);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.out != cur) begin
                            errors++;
                            $display("FAIL %s: got cyc=%0d led=%b busy=%b done=%b step=%0d, required cyc=%0d led=%b busy=%b done=%b step=%0d",
                                     test_name, cyc, cur[6:5], cur[4], cur[3], cur[2:0],
                                     e.cyc, e.out[6:5], e.out[4], e.out[3], e.out[2:0]);
                        end else begin
                            $display("txn %s: cyc=%0d led=%b busy=%b done=%b step=%0d",
                                     test_name, cyc, cur[6:5], cur[4], cur[3], cur[2:0]);
                        end
                    end
                end
                prev_out  = cur;
                have_prev = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic push(input int c, input logic [1:0] l, input logic b,
                        input logic d, input logic [2:0] s);
        exp_t e;
        e.cyc = c;
        e.out = {l, b, d, s};
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s drain: %0d expected changes still pending after %0d cycles, required 0",
                     test_name, exp_q.size(), budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Issue a one-cycle start from a falling edge; the sampling edge is cyc+1.
    task automatic go(input logic [1:0] m, input logic r);
        mode      = m;
        repeat_en = r;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin : stimulus
        int             e;
        int             e2;
        logic [1:0]     hb_led [4];
        int             hb_off [4];

        hb_led[0] = 2'b11; hb_off[0] = 0;
        hb_led[1] = 2'b00; hb_off[1] = 8;
        hb_led[2] = 2'b11; hb_off[2] = 16;
        hb_led[3] = 2'b00; hb_off[3] = 24;

        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; repeat_en = 1'b0;
        #2;
        mon_en = 1'b1;
        push(0, 2'b00, 1'b0, 1'b0, 3'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drain(5);
        repeat (2) @(negedge clk);

        // Mode 0, one shot: 40 cycles of 01, 40 of 10, then done.
        test_name = "mode0_oneshot";
        e = cyc + 1;
        push(e,      2'b01, 1'b1, 1'b0, 3'd0);
        push(e + 40, 2'b10, 1'b1, 1'b0, 3'd1);
        push(e + 80, 2'b00, 1'b0, 1'b1, 3'd0);
        push(e + 81, 2'b00, 1'b0, 1'b0, 3'd0);
        go(2'd0, 1'b0);
        drain(100);
        repeat (5) @(negedge clk);

        // Mode 0 with start coinciding with the final step end: not accepted.
        test_name = "start_at_end";
        e = cyc + 1;
        push(e,      2'b01, 1'b1, 1'b0, 3'd0);
        push(e + 40, 2'b10, 1'b1, 1'b0, 3'd1);
        push(e + 80, 2'b00, 1'b0, 1'b1, 3'd0);
        push(e + 81, 2'b00, 1'b0, 1'b0, 3'd0);
        go(2'd0, 1'b0);
        wait_cyc(e + 79);
        mode  = 2'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain(20);
        repeat (10) @(negedge clk);

        // Mode 3 repeating: 8/8/8/56 cycle steps, wraps 3->0 with no gap.
        test_name = "mode3_repeat";
        e = cyc + 1;
        for (int lp = 0; lp < 3; lp++)
            for (int k = 0; k < 4; k++)
                push(e + 80 * lp + hb_off[k], hb_led[k], 1'b1, 1'b0, 3'(k));
        push(e + 240, 2'b11, 1'b1, 1'b0, 3'd0);
        go(2'd3, 1'b1);
        drain(300);
        push(cyc + 1, 2'b00, 1'b0, 1'b0, 3'd0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        drain(5);
        repeat (3) @(negedge clk);

        // Mode 2, stop on cycle 10, restart on the following cycle.
        test_name = "mode2_stop";
        e = cyc + 1;
        push(e,      2'b01, 1'b1, 1'b0, 3'd0);
        push(e + 8,  2'b10, 1'b1, 1'b0, 3'd1);
        push(e + 10, 2'b00, 1'b0, 1'b0, 3'd0);
        e2 = e + 11;
        push(e2,      2'b01, 1'b1, 1'b0, 3'd0);
        push(e2 + 8,  2'b10, 1'b1, 1'b0, 3'd1);
        push(e2 + 16, 2'b11, 1'b1, 1'b0, 3'd2);
        push(e2 + 24, 2'b00, 1'b1, 1'b0, 3'd3);
        push(e2 + 48, 2'b00, 1'b0, 1'b1, 3'd0);
        push(e2 + 49, 2'b00, 1'b0, 1'b0, 3'd0);
        go(2'd2, 1'b0);
        wait_cyc(e + 9);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        go(2'd2, 1'b0);
        drain(80);
        repeat (3) @(negedge clk);

        // Mode 1: start and mode changes mid-run must not disturb it.
        test_name = "mode1_ignore";
        e = cyc + 1;
        push(e,      2'b11, 1'b1, 1'b0, 3'd0);
        push(e + 16, 2'b00, 1'b1, 1'b0, 3'd1);
        push(e + 32, 2'b00, 1'b0, 1'b1, 3'd0);
        push(e + 33, 2'b00, 1'b0, 1'b0, 3'd0);
        go(2'd1, 1'b0);
        wait_cyc(e + 5);
        go(2'd0, 1'b1);
        wait_cyc(e + 20);
        mode = 2'd2;
        drain(50);
        mode = 2'd0;
        repeat_en = 1'b0;
        repeat (5) @(negedge clk);

        // start and stop together in IDLE: no output may move.
        test_name = "start_stop_idle";
        start = 1'b1;
        stop  = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        repeat (5) @(negedge clk);

        // Asynchronous reset mid-step with the clock halted.
        test_name = "async_reset";
        e = cyc + 1;
        push(e, 2'b01, 1'b1, 1'b0, 3'd0);
        go(2'd0, 1'b0);
        wait_cyc(e + 12);
        clk_en = 1'b0;
        push(e + 12, 2'b00, 1'b0, 1'b0, 3'd0);
        #3;
        rst = 1'b0;
        #5;
        rst = 1'b1;
        #1;
        clk_en = 1'b1;
        drain(5);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Time-multiplexed LED pattern controller for the 12 MHz iCEstick design. It replaces free-running per-LED clock dividers with one shared prescaler and a step sequencer. The sequencer walks a hard-coded table of four blink patterns and drives `led[1:0]` from it. It sits between the board-level top and the LED pins and is started and stopped by user or host control pulses.

## Interface

Parameters:
- `TICK_DIV`, 600000: clock cycles per tick (50 ms at 12 MHz); must be ≥ 2.
- `TICK_WIDTH`, 20: prescaler width; must satisfy 2^TICK_WIDTH ≥ TICK_DIV.

Ports:
- `clk`  in  1  12 MHz system clock; the block's only clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a pattern; honoured only in IDLE.
- `stop`  in  1  one-cycle abort request.
- `mode`  in  2  pattern select; sampled on an accepted `start`.
- `repeat_en`  in  1  loop enable; sampled on an accepted `start`.
- `led`  out  2  LED drive, registered.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse at the natural end of a non-repeating pattern.
- `step_idx`  out  3  current step index, registered.

## Operation

- Pattern table, hard-coded. Each step is {last, led[1:0], dur[4:0]} and holds for (dur+1) ticks.
  - mode 0, alternate: (01,d9), (10,d9,last)
  - mode 1, blink both: (11,d3), (00,d3,last)
  - mode 2, chase: (01,d1), (10,d1), (11,d1), (00,d5,last)
  - mode 3, heartbeat: (11,d1), (00,d1), (11,d1), (00,d13,last)
- States:
  - IDLE: `led`=00, `busy`=0. An accepted `start` latches `mode` and `repeat_en`, clears the prescaler and tick counter, sets `step_idx`=0 and moves to RUN.
  - RUN: `led` = table[mode][step_idx].led. The prescaler counts 0..TICK_DIV-1 and emits an internal tick on wrap. The tick counter counts ticks within the current step.
  - When the tick counter reaches dur, the next tick ends the step:
    - Not last step: `step_idx`+1 and the tick counter clears.
    - Last step with repeat latched: `step_idx`=0 with no gap cycle.
    - Last step without repeat: go to IDLE, pulse `done`, set `led`=00.
- `stop` in RUN: go to IDLE next cycle. `led`=00, `step_idx`=0, no `done`.
- Priority, highest first: `rst` > `stop` > step advance > `start`.
- Simultaneous `start` and `stop` in IDLE: stay in IDLE.
- `start` during RUN is ignored, including the cycle in which RUN exits to IDLE.
- Changes to `mode` and `repeat_en` during RUN have no effect.
- The prescaler and tick counter are never free-running in IDLE; both are held at 0.

## Timing

- Reset, asynchronous and active-low: `led`=00, `busy`=0, `done`=0, `step_idx`=0, state IDLE, all counters 0. Release takes effect on the next `clk` edge.
- `start` sampled high in IDLE at edge N: from edge N+1, `busy`=1, `step_idx`=0 and `led` shows the step 0 value.
- Each step lasts exactly (dur+1)·TICK_DIV cycles. `step_idx` and `led` update on the same edge.
- Non-repeating pattern length is the sum over its steps of (dur+1)·TICK_DIV cycles. Mode 0 is 20·TICK_DIV cycles.
- `done` is high for exactly one cycle, on the same edge at which `busy` falls and `led` becomes 00.
- `stop` sampled at edge N: from edge N+1, `busy`=0 and `led`=00.
- A new `start` is accepted on the first cycle with `busy`=0.
- Reset asserted mid-RUN clears all outputs immediately, without waiting for `clk`.
- Sequencer outputs are all registers; no combinational path from inputs to outputs.

## Test plan

Benches use TICK_DIV=4.
- Mode 0, repeat_en=0, start pulse: `led`=01 for 40 cycles, then 10 for 40 cycles, then `led`=00 with `done`=1 for one cycle and `busy`=0.
- Mode 3, repeat_en=1: steps last 8/8/8/56 cycles with `led` 11/00/11/00. After 80 cycles `step_idx` wraps 3→0 with no gap cycle; this repeats for ≥3 loops and `done` never asserts.
- Mode 2, running: pulse `stop` on cycle 10 → next cycle `led`=00, `busy`=0, `step_idx`=0, no `done`. A `start` on the following cycle restarts at step 0.
- Mode 1 running: pulse `start` with mode=0, and toggle `mode` mid-run → pattern stays 11/00 at 16 cycles per step, unaffected.
- Hold `start` and `stop` high together in IDLE → block stays IDLE. Drive `rst` low mid-step with `clk` stopped → `led`=00 and `busy`=0 asynchronously.
- In mode 0, assert `start` in the same cycle as the final step-end → `done` pulses once, the block returns to IDLE, and that `start` is not accepted.
